// File: rtl/keccak_feeder_pkg.sv
// Shared types and constants for the keccak message feeder.
// Included by the feeder top and its word emitter.
package keccak_feeder_pkg;

    localparam int WORD_BITS   = 32;
    localparam int WORD_BYTES  = 4;
    localparam int DIGEST_BITS = 512;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        VEC,
        STR,
        TAIL,
        WAIT
    } state_t;

    // A partial last word carries the tail; an exact multiple of 4 needs one extra zero-byte word.
    function automatic int bytes_to_beats(input int n);
        return n / WORD_BYTES + 1;
    endfunction

endpackage

// File: rtl/keccak_word_emitter.sv
// Output register stage for words going to the keccak core.
// A requested word is taken only while the core padder has room.
module keccak_word_emitter
    import keccak_feeder_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req,
    input  logic [WORD_BITS-1:0] word,
    input  logic                 is_last,
    input  logic [1:0]           byte_num,
    input  logic                 ke_buffer_full,
    output logic                 accept,
    output logic [WORD_BITS-1:0] ke_in,
    output logic                 ke_in_ready,
    output logic                 ke_is_last,
    output logic [1:0]           ke_byte_num
);

    assign accept = req && !ke_buffer_full;

    // Output stage: one registered word per accepted request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ke_in       <= '0;
            ke_in_ready <= 1'b0;
            ke_is_last  <= 1'b0;
            ke_byte_num <= 2'd0;
        end else begin
            ke_in_ready <= accept;
            if (accept) begin
                ke_in       <= word;
                ke_is_last  <= is_last;
                ke_byte_num <= byte_num;
            end
        end
    end

endmodule

// File: rtl/keccak_msg_feeder.sv
// Front-end for the keccak sponge core: hashes a wide vector or a byte-length word stream,
// clears the core before each message and holds the captured digest.
module keccak_msg_feeder
    import keccak_feeder_pkg::*;
#(
    parameter int VEC_BITS = 704
)
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start_vec,
    input  logic [VEC_BITS-1:0]    data_vec,
    input  logic                   start_str,
    input  logic [WORD_BITS-1:0]   s_data,
    input  logic                   s_valid,
    input  logic                   s_last,
    input  logic [2:0]             s_bytes,
    output logic                   s_ready,
    output logic                   ke_clr,
    output logic [WORD_BITS-1:0]   ke_in,
    output logic                   ke_in_ready,
    output logic                   ke_is_last,
    output logic [1:0]             ke_byte_num,
    input  logic                   ke_buffer_full,
    input  logic [DIGEST_BITS-1:0] ke_out,
    input  logic                   ke_out_ready,
    output logic                   busy,
    output logic [DIGEST_BITS-1:0] digest,
    output logic                   digest_valid,
    output logic                   start_ignored
);

    localparam int VEC_BYTES = VEC_BITS / 8;
    localparam int CNT_W     = $clog2(VEC_BYTES + 1);
    // Short vectors still need a full word to slice from.
    localparam int SH_W      = (VEC_BITS < WORD_BITS) ? WORD_BITS : VEC_BITS;

    state_t               state, state_nx;
    logic                 use_vec;
    logic [SH_W-1:0]      shreg;
    logic [CNT_W-1:0]     rem;
    logic [31:0]          rem_w;
    logic [2:0]           s_nb;
    logic                 req, is_last, accept;
    logic [WORD_BITS-1:0] word;
    logic [1:0]           byte_num;

    assign rem_w   = 32'(rem);
    assign s_nb    = (s_bytes > 3'd4) ? 3'd4 : s_bytes;
    assign s_ready = (state == STR) && !ke_buffer_full;
    assign busy    = (state != IDLE);

    always_comb begin
        state_nx = state;
        req      = 1'b0;
        word     = '0;
        is_last  = 1'b0;
        byte_num = 2'd0;
        unique case (state)
            IDLE: if (start_vec || start_str) state_nx = CLR;
            CLR:  state_nx = use_vec ? VEC : STR;
            VEC: begin
                req  = 1'b1;
                word = shreg[WORD_BITS-1:0];
                if (rem_w == 32'd4) begin
                    if (accept) state_nx = TAIL;
                end else if (rem_w < 32'd4) begin
                    is_last  = 1'b1;
                    byte_num = rem_w[1:0];
                    if (accept) state_nx = WAIT;
                end
            end
            STR: begin
                req  = s_valid;
                word = s_data;
                if (s_last) begin
                    if (s_nb == 3'd4) begin
                        if (accept) state_nx = TAIL;
                    end else begin
                        // Zero valid bytes is the empty terminator word.
                        is_last  = 1'b1;
                        byte_num = s_nb[1:0];
                        if (s_nb == 3'd0) word = '0;
                        if (accept) state_nx = WAIT;
                    end
                end
            end
            TAIL: begin
                req     = 1'b1;
                is_last = 1'b1;
                if (accept) state_nx = WAIT;
            end
            WAIT: if (ke_out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            use_vec       <= 1'b0;
            shreg         <= '0;
            rem           <= '0;
            ke_clr        <= 1'b0;
            start_ignored <= 1'b0;
            digest        <= '0;
            digest_valid  <= 1'b0;
        end else begin
            state         <= state_nx;
            ke_clr        <= (state_nx == CLR);
            start_ignored <= (state == IDLE) ? (start_vec && start_str) : (start_vec || start_str);
            if (state == IDLE && (start_vec || start_str)) begin
                use_vec      <= start_vec;
                digest_valid <= 1'b0;
            end
            if (state == IDLE && start_vec) begin
                shreg <= SH_W'(data_vec);
                rem   <= CNT_W'(VEC_BYTES);
            end else if (state == VEC && accept) begin
                shreg <= shreg >> WORD_BITS;
                if (rem_w > 32'd4) rem <= CNT_W'(rem_w - 32'd4);
            end
            if (state == WAIT && ke_out_ready) begin
                digest       <= ke_out;
                digest_valid <= 1'b1;
            end
        end
    end

    keccak_word_emitter u_emit (
        .clk            (clk),
        .reset          (reset),
        .req            (req),
        .word           (word),
        .is_last        (is_last),
        .byte_num       (byte_num),
        .ke_buffer_full (ke_buffer_full),
        .accept         (accept),
        .ke_in          (ke_in),
        .ke_in_ready    (ke_in_ready),
        .ke_is_last     (ke_is_last),
        .ke_byte_num    (ke_byte_num)
    );

endmodule

// File: tb/tb_keccak_msg_feeder.sv
// Directed bench for keccak_msg_feeder: 704-bit and 72-bit vectors, stream messages,
// stalls, start conflicts and mid-message reset.
module tb_keccak_msg_feeder;

    localparam int EXP_BEATS = 23;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start_vec = 1'b0, start_str = 1'b0;
    logic [703:0] data_vec = '0;
    logic [31:0]  s_data = '0;
    logic         s_valid = 1'b0, s_last = 1'b0;
    logic [2:0]   s_bytes = '0;
    logic         s_ready, ke_clr, ke_in_ready, ke_is_last, busy, digest_valid, start_ignored;
    logic [31:0]  ke_in;
    logic [1:0]   ke_byte_num;
    logic         ke_buffer_full = 1'b0, ke_out_ready = 1'b0;
    logic [511:0] ke_out = '0, digest;

    logic         start_vec72 = 1'b0, ke_out_ready72 = 1'b0, zero_b = 1'b0;
    logic [71:0]  data_vec72 = '0;
    logic         s_ready72, ke_clr72, ke_in_ready72, ke_is_last72, busy72, digest_valid72, start_ignored72;
    logic [31:0]  ke_in72;
    logic [1:0]   ke_byte_num72;
    logic [511:0] digest72;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] mw[$];
    bit          ml[$];
    logic [1:0]  mb[$];
    int          clr_cnt = 0;

    always #5 clk = ~clk;

    keccak_msg_feeder #(.VEC_BITS(704)) dut (
        .clk(clk), .reset(reset), .start_vec(start_vec), .data_vec(data_vec),
        .start_str(start_str), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
        .s_bytes(s_bytes), .s_ready(s_ready), .ke_clr(ke_clr), .ke_in(ke_in),
        .ke_in_ready(ke_in_ready), .ke_is_last(ke_is_last), .ke_byte_num(ke_byte_num),
        .ke_buffer_full(ke_buffer_full), .ke_out(ke_out), .ke_out_ready(ke_out_ready),
        .busy(busy), .digest(digest), .digest_valid(digest_valid), .start_ignored(start_ignored)
    );

    keccak_msg_feeder #(.VEC_BITS(72)) dut72 (
        .clk(clk), .reset(reset), .start_vec(start_vec72), .data_vec(data_vec72),
        .start_str(zero_b), .s_data(s_data), .s_valid(zero_b), .s_last(zero_b),
        .s_bytes(s_bytes), .s_ready(s_ready72), .ke_clr(ke_clr72), .ke_in(ke_in72),
        .ke_in_ready(ke_in_ready72), .ke_is_last(ke_is_last72), .ke_byte_num(ke_byte_num72),
        .ke_buffer_full(zero_b), .ke_out(ke_out), .ke_out_ready(ke_out_ready72),
        .busy(busy72), .digest(digest72), .digest_valid(digest_valid72), .start_ignored(start_ignored72)
    );

    // Log every word the 704-bit feeder hands to the core.
    always @(negedge clk) begin
        if (ke_in_ready) begin
            mw.push_back(ke_in);
            ml.push_back(ke_is_last);
            mb.push_back(ke_byte_num);
        end
        if (ke_clr) clr_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        mw.delete(); ml.delete(); mb.delete();
        clr_cnt = 0;
    endtask

    function automatic logic [703:0] make_vec(input logic [7:0] base);
        logic [703:0] v;
        for (int i = 0; i < 88; i++) v[8*i +: 8] = base + 8'(i);
        return v;
    endfunction

    function automatic logic [31:0] exp_word(input logic [7:0] base, input int k);
        logic [31:0] w;
        if (k >= 22) return 32'h0;
        for (int j = 0; j < 4; j++) w[8*j +: 8] = base + 8'(4*k + j);
        return w;
    endfunction

    task automatic wait_last(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            tick();
            if (ml.size() > 0 && ml[ml.size()-1]) ok = 1'b1;
        end
    endtask

    task automatic wait_words(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            tick();
            if (mw.size() >= n) ok = 1'b1;
        end
    endtask

    task automatic drive_digest(input logic [511:0] val);
        ke_out = val;
        ke_out_ready = 1'b1;
        tick();
        ke_out_ready = 1'b0;
    endtask

    task automatic run_stream(input int n, input logic [2:0] lastb, input logic [31:0] base, output bit ok);
        bit acc;
        ok = 1'b1;
        clear_mon();
        start_str = 1'b1; tick(); start_str = 1'b0;
        for (int i = 0; i < n; i++) begin
            s_valid = 1'b1; s_data = base + 32'(i); s_last = (i == n-1); s_bytes = lastb;
            acc = 1'b0;
            for (int c = 0; c < 20 && !acc; c++) begin
                acc = s_ready;
                tick();
            end
            if (!acc) ok = 1'b0;
        end
        s_valid = 1'b0; s_last = 1'b0; s_bytes = 3'd0;
        if (ok) wait_last(ok);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick(); tick();
        vectors++; if (ke_in_ready !== 1'b0 || ke_clr !== 1'b0 || ke_in !== 32'h0) begin
            miscompares++; $display("FAIL reset_ke: ready=%b clr=%b in=%h, required 0 0 0", ke_in_ready, ke_clr, ke_in); end
        vectors++; if (busy !== 1'b0 || s_ready !== 1'b0 || start_ignored !== 1'b0) begin
            miscompares++; $display("FAIL reset_ctl: busy=%b s_ready=%b ign=%b, required 0", busy, s_ready, start_ignored); end
        vectors++; if (digest_valid !== 1'b0 || digest !== 512'h0) begin
            miscompares++; $display("FAIL reset_digest: valid=%b digest_nonzero=%b, required 0", digest_valid, |digest); end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_vec704();
        bit ok; int bad;
        clear_mon();
        data_vec = make_vec(8'h00);
        start_vec = 1'b1; tick(); start_vec = 1'b0;
        vectors++; if (ke_clr !== 1'b1 || busy !== 1'b1) begin
            miscompares++; $display("FAIL vec_clr: clr=%b busy=%b, required 1 1", ke_clr, busy); end
        tick();
        vectors++; if (ke_clr !== 1'b0 || ke_in_ready !== 1'b0) begin
            miscompares++; $display("FAIL vec_clr_end: clr=%b ready=%b, required 0 0", ke_clr, ke_in_ready); end
        tick();
        vectors++; if (ke_in_ready !== 1'b1 || ke_in !== 32'h03020100) begin
            miscompares++; $display("FAIL vec_first: ready=%b in=%h, required 1 03020100", ke_in_ready, ke_in); end
        wait_last(ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL vec_timeout: no last word seen"); end
        bad = 0;
        for (int k = 0; k < mw.size(); k++)
            if (mw[k] !== exp_word(8'h00, k) || ml[k] !== (k == 22) || mb[k] !== 2'd0) bad++;
        vectors++; if (bad != 0 || mw.size() != EXP_BEATS) begin
            miscompares++; $display("FAIL vec_words: %0d bad of %0d, required 0 bad of %0d", bad, mw.size(), EXP_BEATS); end
        vectors++; if (clr_cnt != 1) begin
            miscompares++; $display("FAIL vec_clr_count: %0d cycles, required 1", clr_cnt); end
        drive_digest({16{32'hC0DE0001}});
        vectors++; if (digest !== {16{32'hC0DE0001}} || digest_valid !== 1'b1 || busy !== 1'b0) begin
            miscompares++; $display("FAIL vec_digest: word0=%h valid=%b busy=%b, required c0de0001 1 0", digest[31:0], digest_valid, busy); end
    endtask

    task automatic test_vec72();
        logic [31:0] w[$]; bit l[$]; logic [1:0] b[$];
        data_vec72 = 72'hA8A7A6A5A4A3A2A1A0;
        start_vec72 = 1'b1; tick(); start_vec72 = 1'b0;
        for (int i = 0; i < 20 && !(l.size() > 0 && l[l.size()-1]); i++) begin
            tick();
            if (ke_in_ready72) begin w.push_back(ke_in72); l.push_back(ke_is_last72); b.push_back(ke_byte_num72); end
        end
        vectors++; if (w.size() != 3) begin
            miscompares++; $display("FAIL v72_count: %0d beats, required 3", w.size()); end
        else begin
            vectors++; if (w[0] !== 32'hA3A2A1A0 || w[1] !== 32'hA7A6A5A4 || l[0] || l[1]) begin
                miscompares++; $display("FAIL v72_full: %h %h last=%b%b, required a3a2a1a0 a7a6a5a4 00", w[0], w[1], l[0], l[1]); end
            vectors++; if (l[2] !== 1'b1 || b[2] !== 2'd1 || w[2][7:0] !== 8'hA8) begin
                miscompares++; $display("FAIL v72_tail: last=%b bn=%0d byte=%h, required 1 1 a8", l[2], b[2], w[2][7:0]); end
        end
        ke_out = {16{32'h72727272}};
        ke_out_ready72 = 1'b1; tick(); ke_out_ready72 = 1'b0;
        vectors++; if (digest72 !== {16{32'h72727272}} || digest_valid72 !== 1'b1 || busy72 !== 1'b0) begin
            miscompares++; $display("FAIL v72_digest: word0=%h valid=%b, required 72727272 1", digest72[31:0], digest_valid72); end
    endtask

    task automatic test_stream();
        bit ok;
        run_stream(3, 3'd2, 32'h11110000, ok);
        vectors++; if (!ok || mw.size() != 3) begin
            miscompares++; $display("FAIL str2_count: ok=%b beats=%0d, required 1 3", ok, mw.size()); end
        else begin
            vectors++; if (mw[2] !== 32'h11110002 || ml[2] !== 1'b1 || mb[2] !== 2'd2 || ml[0] || ml[1]) begin
                miscompares++; $display("FAIL str2_last: in=%h last=%b bn=%0d, required 11110002 1 2", mw[2], ml[2], mb[2]); end
        end
        drive_digest({16{32'h5EED0002}});
        vectors++; if (digest !== {16{32'h5EED0002}} || digest_valid !== 1'b1) begin
            miscompares++; $display("FAIL str2_digest: word0=%h valid=%b, required 5eed0002 1", digest[31:0], digest_valid); end

        run_stream(3, 3'd4, 32'h22220000, ok);
        vectors++; if (!ok || mw.size() != 4) begin
            miscompares++; $display("FAIL str4_count: ok=%b beats=%0d, required 1 4", ok, mw.size()); end
        else begin
            vectors++; if (mw[2] !== 32'h22220002 || ml[2] || mw[3] !== 32'h0 || ml[3] !== 1'b1 || mb[3] !== 2'd0) begin
                miscompares++; $display("FAIL str4_term: w2=%h l2=%b w3=%h l3=%b bn=%0d, required 22220002 0 0 1 0", mw[2], ml[2], mw[3], ml[3], mb[3]); end
        end
        drive_digest({16{32'h5EED0004}});

        run_stream(1, 3'd0, 32'h33330000, ok);
        vectors++; if (!ok || mw.size() != 1) begin
            miscompares++; $display("FAIL str0_count: ok=%b beats=%0d, required 1 1", ok, mw.size()); end
        else begin
            vectors++; if (mw[0] !== 32'h0 || ml[0] !== 1'b1 || mb[0] !== 2'd0) begin
                miscompares++; $display("FAIL str0_empty: in=%h last=%b bn=%0d, required 0 1 0", mw[0], ml[0], mb[0]); end
        end
        drive_digest({16{32'h5EED0000}});

        run_stream(1, 3'd7, 32'h44440000, ok);
        vectors++; if (!ok || mw.size() != 2) begin
            miscompares++; $display("FAIL str7_count: ok=%b beats=%0d, required 1 2", ok, mw.size()); end
        else begin
            vectors++; if (mw[0] !== 32'h44440000 || ml[0] || mw[1] !== 32'h0 || ml[1] !== 1'b1) begin
                miscompares++; $display("FAIL str7_clamp: w0=%h l0=%b w1=%h l1=%b, required 44440000 0 0 1", mw[0], ml[0], mw[1], ml[1]); end
        end
        drive_digest({16{32'h5EED0007}});
    endtask

    task automatic test_stall();
        bit ok; int bad, sz0;
        clear_mon();
        data_vec = make_vec(8'h10);
        start_vec = 1'b1; tick(); start_vec = 1'b0;
        wait_words(5, ok);
        ke_buffer_full = 1'b1;
        tick();
        sz0 = mw.size();
        for (int c = 0; c < 4; c++) begin
            vectors++; if (ke_in_ready !== 1'b0 || s_ready !== 1'b0) begin
                miscompares++; $display("FAIL stall_hold: cycle %0d ready=%b s_ready=%b, required 0 0", c, ke_in_ready, s_ready); end
            tick();
        end
        ke_buffer_full = 1'b0;
        vectors++; if (mw.size() != sz0) begin
            miscompares++; $display("FAIL stall_no_words: %0d words, required %0d", mw.size(), sz0); end
        if (ok) wait_last(ok);
        bad = 0;
        for (int k = 0; k < mw.size(); k++)
            if (mw[k] !== exp_word(8'h10, k) || ml[k] !== (k == 22)) bad++;
        vectors++; if (!ok || bad != 0 || mw.size() != EXP_BEATS) begin
            miscompares++; $display("FAIL stall_words: ok=%b %0d bad of %0d, required 1 0 of %0d", ok, bad, mw.size(), EXP_BEATS); end
        drive_digest({16{32'h57A11000}});

        clear_mon();
        start_str = 1'b1; tick(); start_str = 1'b0; tick();
        ke_buffer_full = 1'b1;
        s_valid = 1'b1; s_data = 32'hDEAD0001; s_last = 1'b1; s_bytes = 3'd3;
        for (int c = 0; c < 3; c++) begin
            #1;
            vectors++; if (s_ready !== 1'b0) begin
                miscompares++; $display("FAIL stall_s_ready: cycle %0d s_ready=%b, required 0", c, s_ready); end
            tick();
        end
        ke_buffer_full = 1'b0;
        #1;
        vectors++; if (s_ready !== 1'b1 || mw.size() != 0) begin
            miscompares++; $display("FAIL stall_release: s_ready=%b words=%0d, required 1 0", s_ready, mw.size()); end
        tick();
        s_valid = 1'b0; s_last = 1'b0; s_bytes = 3'd0;
        wait_last(ok);
        vectors++; if (!ok || mw.size() != 1 || mw[0] !== 32'hDEAD0001 || mb[0] !== 2'd3) begin
            miscompares++; $display("FAIL stall_str_word: ok=%b beats=%0d, required 1 1 word dead0001 bn 3", ok, mw.size()); end
        drive_digest({16{32'h57A11001}});
    endtask

    task automatic test_start_conflict();
        bit ok; int pulses;
        clear_mon();
        data_vec = make_vec(8'h20);
        start_vec = 1'b1; start_str = 1'b1; tick(); start_vec = 1'b0; start_str = 1'b0;
        vectors++; if (start_ignored !== 1'b1 || digest_valid !== 1'b0 || ke_clr !== 1'b1) begin
            miscompares++; $display("FAIL both_start: ign=%b dvalid=%b clr=%b, required 1 0 1", start_ignored, digest_valid, ke_clr); end
        tick();
        vectors++; if (start_ignored !== 1'b0) begin
            miscompares++; $display("FAIL both_pulse_len: ign=%b, required 0", start_ignored); end
        tick(); tick();
        start_str = 1'b1; tick(); start_str = 1'b0;
        pulses = int'(start_ignored);
        tick(); pulses += int'(start_ignored);
        tick(); pulses += int'(start_ignored);
        vectors++; if (pulses != 1) begin
            miscompares++; $display("FAIL busy_drop: %0d pulses, required 1", pulses); end
        wait_last(ok);
        vectors++; if (!ok || mw.size() != EXP_BEATS || mw[0] !== 32'h23222120) begin
            miscompares++; $display("FAIL both_vec_path: ok=%b beats=%0d, required 1 %0d first 23222120", ok, mw.size(), EXP_BEATS); end
        drive_digest({16{32'hB07B0000}});
    endtask

    task automatic test_reset_mid();
        bit ok; int bad;
        clear_mon();
        data_vec = make_vec(8'h80);
        start_vec = 1'b1; tick(); start_vec = 1'b0;
        wait_words(10, ok);
        #2 reset = 1'b0;
        #1;
        vectors++; if (!ok || ke_in_ready !== 1'b0 || busy !== 1'b0 || ke_clr !== 1'b0 || ke_in !== 32'h0) begin
            miscompares++; $display("FAIL mid_reset_ke: ok=%b ready=%b busy=%b in=%h, required 1 0 0 0", ok, ke_in_ready, busy, ke_in); end
        vectors++; if (digest_valid !== 1'b0 || digest !== 512'h0) begin
            miscompares++; $display("FAIL mid_reset_digest: valid=%b nonzero=%b, required 0 0", digest_valid, |digest); end
        tick(); tick();
        reset = 1'b1;
        tick();
        clear_mon();
        start_vec = 1'b1; tick(); start_vec = 1'b0;
        wait_last(ok);
        bad = 0;
        for (int k = 0; k < mw.size(); k++)
            if (mw[k] !== exp_word(8'h80, k) || ml[k] !== (k == 22)) bad++;
        vectors++; if (!ok || bad != 0 || mw.size() != EXP_BEATS) begin
            miscompares++; $display("FAIL mid_reset_rerun: ok=%b %0d bad of %0d, required 1 0 of %0d", ok, bad, mw.size(), EXP_BEATS); end
        drive_digest({16{32'hF2E5D000}});
        vectors++; if (digest !== {16{32'hF2E5D000}} || digest_valid !== 1'b1) begin
            miscompares++; $display("FAIL mid_reset_digest_new: word0=%h valid=%b, required f2e5d000 1", digest[31:0], digest_valid); end
    endtask

    initial begin
        test_reset();
        test_vec704();
        test_vec72();
        test_stream();
        test_stall();
        test_start_conflict();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
